// File: rtl/reg_cmd_if.sv
// Button/switch inputs and registered command outputs of the register command front-end.
interface reg_cmd_if;
    logic [3:0] btn;
    logic [7:0] sw;
    logic [3:0] cmd;
    logic [7:0] data_out;
    logic       busy;
    logic [3:0] pending;

    modport master (output btn, sw, input cmd, data_out, busy, pending);
    modport slave  (input btn, sw, output cmd, data_out, busy, pending);
endinterface

// File: rtl/reg_cmd_ctrl.sv
// Push-button command front-end: per-button sync/debounce/edge detect, pending latch,
// and a fixed-priority arbiter issuing one-hot single-cycle register commands.
module reg_cmd_btn #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          deb, deb_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            deb      <= 1'b0;
            deb_prev <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_q   <= {sync_q[0], raw};
            deb_prev <= deb;
            if (sync_q[1] == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                // level has disagreed for DEB_CYCLES consecutive cycles: accept it
                deb <= sync_q[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rise = deb & ~deb_prev;
endmodule

module reg_cmd_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    reg_cmd_if.slave  bus
);
    localparam int NB = 4;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t          state, state_nxt;
    logic [NB-1:0]   rise, grant, pend_q, cmd_q;
    logic [7:0]      data_q;
    logic            busy_q;
    logic [GW-1:0]   gap_cnt;

    for (genvar i = 0; i < NB; i++) begin : g_btn
        reg_cmd_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (bus.btn[i]),
            .rise (rise[i])
        );
    end

    // State and registered outputs; cmd is the grant delayed one edge, so it is high
    // exactly during the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend_q  <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state  <= state_nxt;
            pend_q <= (pend_q & ~grant) | rise;
            cmd_q  <= grant;
            busy_q <= (state_nxt != IDLE);
            if (grant[1])
                data_q <= bus.sw;
            if (state == ISSUE)
                gap_cnt <= GW'(GAP_CYCLES);
            else if (state == GAP)
                gap_cnt <= gap_cnt - GW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pend_q) state_nxt = ISSUE;
            ISSUE:   state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (gap_cnt == GW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fixed priority: clear > load > inc > dec.
    always_comb begin
        grant = '0;
        if (state == IDLE) begin
            if      (pend_q[0]) grant = 4'b0001;
            else if (pend_q[1]) grant = 4'b0010;
            else if (pend_q[2]) grant = 4'b0100;
            else if (pend_q[3]) grant = 4'b1000;
        end
    end

    assign bus.cmd      = cmd_q;
    assign bus.data_out = data_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pend_q;
endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl: default-parameter instance plus a DEB=1/GAP=0 instance.
module tb_reg_cmd_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    reg_cmd_if if0 ();
    reg_cmd_if if1 ();

    reg_cmd_ctrl #(.DEB_CYCLES(4), .GAP_CYCLES(2)) u_def (.clk(clk), .rst_n(rst_n), .bus(if0));
    reg_cmd_ctrl #(.DEB_CYCLES(1), .GAP_CYCLES(0)) u_g0  (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [3:0]      btn;
        logic [7:0]      sw;
        int              hold;
        int              n_exp;
        logic [3:0][3:0] exp_cmd;   // [0] is the first expected command
        logic [7:0]      exp_data;
    } vec_t;

    localparam int WIN = 32;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int         ncmd;
        int         cyc[4];
        logic [3:0] got[4];
        logic [7:0] dat_at_load;
        bit         bad_oh;
        ncmd = 0;
        bad_oh = 1'b0;
        dat_at_load = 8'h00;
        if0.sw  = v.sw;
        if0.btn = v.btn;
        for (int c = 1; c <= WIN; c++) begin
            step();
            if (c == v.hold) if0.btn = 4'b0;
            if (!$onehot0(if0.cmd)) bad_oh = 1'b1;
            if (if0.cmd != 4'b0) begin
                if (ncmd < 4) begin
                    got[ncmd] = if0.cmd;
                    cyc[ncmd] = c;
                end
                if (if0.cmd[1]) dat_at_load = if0.data_out;
                ncmd++;
            end
        end
        check($sformatf("v%0d cmd count", id), ncmd, v.n_exp);
        check($sformatf("v%0d onehot", id), {31'b0, bad_oh}, 32'd0);
        for (int k = 0; k < v.n_exp && k < ncmd && k < 4; k++) begin
            check($sformatf("v%0d cmd[%0d]", id, k), got[k], v.exp_cmd[k]);
            if (k == 0) check($sformatf("v%0d latency", id), cyc[0], 8);
            else        check($sformatf("v%0d spacing[%0d]", id, k), cyc[k] - cyc[k-1], 4);
        end
        if (v.btn[1]) check($sformatf("v%0d data at load", id), dat_at_load, v.sw);
        check($sformatf("v%0d data_out", id), if0.data_out, v.exp_data);
        check($sformatf("v%0d pending end", id), if0.pending, 4'b0);
        check($sformatf("v%0d busy end", id), if0.busy, 1'b0);
    endtask

    initial begin
        logic [3:0] seq[16];
        int         bad;

        vecs[0] = '{4'b0100, 8'h00, 20, 1, {4'h0, 4'h0, 4'h0, 4'h4}, 8'h00};
        vecs[1] = '{4'b1000, 8'h00,  3, 0, {4'h0, 4'h0, 4'h0, 4'h0}, 8'h00};
        vecs[2] = '{4'b1000, 8'h00,  4, 1, {4'h0, 4'h0, 4'h0, 4'h8}, 8'h00};
        vecs[3] = '{4'b0010, 8'hA5,  6, 1, {4'h0, 4'h0, 4'h0, 4'h2}, 8'hA5};
        vecs[4] = '{4'b0100, 8'h3C,  6, 1, {4'h0, 4'h0, 4'h0, 4'h4}, 8'hA5};
        vecs[5] = '{4'b1111, 8'h5A,  6, 4, {4'h8, 4'h4, 4'h2, 4'h1}, 8'h5A};
        vecs[6] = '{4'b0000, 8'hFF,  1, 0, {4'h0, 4'h0, 4'h0, 4'h0}, 8'h5A};

        rst_n = 1'b0;
        if0.btn = '0; if0.sw = '0;
        if1.btn = '0; if1.sw = '0;
        step(); step();
        check("reset outputs", {if0.cmd, if0.data_out, if0.busy, if0.pending}, 17'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if ({if0.cmd, if0.data_out, if0.busy, if0.pending} != 17'd0) bad++;
        end
        check("idle 20 cycles", bad, 0);

        // bounce: 2-cycle high/low toggling never survives the debounce window
        bad = 0;
        for (int c = 0; c < 26; c++) begin
            if0.btn[3] = (c < 6) ? (((c / 2) % 2) == 0) : 1'b0;
            step();
            if (if0.cmd != 4'b0 || if0.pending != 4'b0) bad++;
        end
        check("bounce rejected", bad, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // DEB=1, GAP=0: inc and dec together
        if1.btn = 4'b1100;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 4) if1.btn = 4'b0;
            seq[c] = if1.cmd;
        end
        check("g0 inc pulse", seq[5], 4'b0100);
        check("g0 zero between", seq[6], 4'b0000);
        check("g0 dec pulse", seq[7], 4'b1000);
        bad = 0;
        for (int c = 1; c <= 12; c++) if (c != 5 && c != 7 && seq[c] != 4'b0) bad++;
        check("g0 no stray cmd", bad, 0);

        // DEB=1, GAP=0: re-press inc so its rise lands in the first inc's ISSUE cycle
        if1.btn = 4'b0100;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 1 || c == 3) if1.btn = 4'b0000;
            if (c == 2)           if1.btn = 4'b0100;
            seq[c] = if1.cmd;
            if (c == 6) check("g0 repress pending", if1.pending, 4'b0100);
        end
        check("g0 first inc", seq[5], 4'b0100);
        check("g0 second inc", seq[7], 4'b0100);
        bad = 0;
        for (int c = 1; c <= 14; c++) if (seq[c] != 4'b0) bad++;
        check("g0 repress count", bad, 2);

        // reset in the middle of a GAP with inc still pending
        if0.btn = 4'b0101;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 6) if0.btn = 4'b0;
            if (c == 8) check("pre-reset clear cmd", if0.cmd, 4'b0001);
        end
        check("pre-reset pending", if0.pending, 4'b0100);
        check("pre-reset busy", if0.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {if0.cmd, if0.data_out, if0.busy, if0.pending}, 17'd0);
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (if0.cmd != 4'b0 || if0.pending != 4'b0) bad++;
        end
        check("no cmd after reset", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
